// File: rtl/mantissa_mul_iter_if.sv
// Operand / result handshake bundle for the iterative mantissa multiplier.
// master: operand producer and result consumer; slave: the multiplier.
interface mantissa_mul_iter_if #(
    parameter int MW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] Xm;
    logic [MW-1:0] Ym;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] Zm;
    logic          PM;
    logic          rnd_ovf;

    modport master (
        output in_valid, Xm, Ym, out_ready,
        input  in_ready, out_valid, Zm, PM, rnd_ovf
    );

    modport slave (
        input  in_valid, Xm, Ym, out_ready,
        output in_ready, out_valid, Zm, PM, rnd_ovf
    );
endinterface

// File: rtl/mantissa_mul_iter.sv
// Iterative radix-2 shift-add multiplier for {1,Xm} x {1,Ym}, followed by a
// one-cycle normalisation to a MW-bit mantissa plus exponent-adjust flags.
// Optional build macro: MANTISSA_ROUND_NEAREST_EN selects round-to-nearest-even
// in normalisation; without it the mantissa is truncated and rnd_ovf stays 0.
module mantissa_mul_iter #(
    parameter int MW = 7
) (
    input  logic                clk,
    input  logic                rst,
    mantissa_mul_iter_if.slave  bus
);
    localparam int PW = 2*MW + 2;
    localparam int CW = $clog2(MW + 2);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t        state;
    logic [PW-1:0] acc;
    logic [PW-1:0] pp;
    logic [PW-1:0] mcand;
    logic [MW:0]   mplier;
    logic [CW-1:0] cnt;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [MW-1:0] zm_q;
    logic          pm_q;
    logic          rnd_q;

    logic          pm_c;
    logic [MW-1:0] zm_c;
    logic          rnd_c;

`ifdef MANTISSA_ROUND_NEAREST_EN
    logic [PW-2:0] np;
    logic [MW-1:0] zt;
    logic [MW:0]   inc;
    logic          guard;
    logic          sticky;

    // Normalise so the leading 1 sits at the top, then round-to-nearest-even
    always_comb begin
        pm_c   = acc[PW-1];
        np     = pm_c ? acc[PW-2:0] : {acc[PW-3:0], 1'b0};
        zt     = np[PW-2:MW+1];
        guard  = np[MW];
        sticky = |np[MW-1:0];
        inc    = {1'b0, zt} + {{MW{1'b0}}, 1'b1};
        zm_c   = zt;
        rnd_c  = 1'b0;
        if (guard & (sticky | zt[0])) begin
            // Carry out of {1,Zm} means the mantissa wrapped to 1.000..0
            if (inc[MW]) begin
                zm_c  = '0;
                rnd_c = 1'b1;
            end else begin
                zm_c  = inc[MW-1:0];
            end
        end
    end
`else
    // Normalise by truncation: take the MW bits below the leading 1
    always_comb begin
        pm_c  = acc[PW-1];
        zm_c  = pm_c ? acc[PW-2:MW+1] : acc[PW-3:MW];
        rnd_c = 1'b0;
    end
`endif

    // Control FSM and datapath. The partial product is registered one cycle
    // ahead of the accumulate, so the counter runs one step past MW to drain
    // the last partial product before normalisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            pp          <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            zm_q        <= '0;
            pm_q        <= 1'b0;
            rnd_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand      <= PW'({1'b1, bus.Xm});
                        mplier     <= {1'b1, bus.Ym};
                        acc        <= '0;
                        pp         <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= MUL;
                    end
                end
                MUL: begin
                    acc    <= acc + pp;
                    pp     <= mplier[0] ? mcand : '0;
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(MW + 1))
                        state <= NORM;
                end
                NORM: begin
                    zm_q        <= zm_c;
                    pm_q        <= pm_c;
                    rnd_q       <= rnd_c;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Zm        = zm_q;
    assign bus.PM        = pm_q;
    assign bus.rnd_ovf   = rnd_q;
endmodule

// File: tb/tb_mantissa_mul_iter.sv
// Directed bench for mantissa_mul_iter (MW=7): latency, products, rounding
// build differences, output hold under backpressure and mid-operation reset.
module tb_mantissa_mul_iter;
    localparam int MW = 7;
`ifdef MANTISSA_ROUND_NEAREST_EN
    localparam bit RN = 1'b1;
`else
    localparam bit RN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mantissa_mul_iter_if #(.MW(MW)) bus ();

    mantissa_mul_iter #(.MW(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, check latency and results, hold for 'hold' cycles,
    // then take the result and check the return to IDLE.
    task automatic run_op(input logic [6:0] x, input logic [6:0] y,
                          input logic [6:0] ezm, input logic epm, input logic erov,
                          input int hold, input string tag);
        int n;
        chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
        bus.Xm       = x;
        bus.Ym       = y;
        bus.in_valid = 1'b1;
        tick();
        // operands change and in_valid lingers after acceptance: must be ignored
        bus.Xm = ~x;
        bus.Ym = ~y;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
            if (n == 2) bus.in_valid = 1'b0;
            if (bus.in_ready && bus.out_valid) chk({tag, ".overlap"}, 32'd1, 32'd0);
        end
        bus.in_valid = 1'b0;
        chk({tag, ".lat"}, 32'(n), 32'(MW + 3));
        chk({tag, ".zm"}, 32'(bus.Zm), 32'(ezm));
        chk({tag, ".pm"}, 32'(bus.PM), 32'(epm));
        chk({tag, ".rov"}, 32'(bus.rnd_ovf), 32'(erov));
        chk({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_v"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_zm"}, 32'(bus.Zm), 32'(ezm));
            chk({tag, ".hold_pm"}, 32'(bus.PM), 32'(epm));
            chk({tag, ".hold_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".ov_clr"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int  saw;
        bus.in_valid  = 1'b1;  // presented during reset: must not be taken
        bus.Xm        = 7'h40;
        bus.Ym        = 7'h40;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        chk("rst.ov",  32'(bus.out_valid), 32'd0);
        chk("rst.zm",  32'(bus.Zm), 32'd0);
        chk("rst.pm",  32'(bus.PM), 32'd0);
        chk("rst.rov", 32'(bus.rnd_ovf), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("rst.rdy", 32'(bus.in_ready), 32'd1);
        chk("rst.noacc", 32'(bus.out_valid), 32'd0);

        // 1.0 x 1.0
        run_op(7'h00, 7'h00, 7'h00, 1'b0, 1'b0, 0, "one");
        // 1.5 x 1.5 = 2.25, P=0x9000
        run_op(7'h40, 7'h40, 7'h10, 1'b1, 1'b0, 0, "p15");
        // P=0x60C0: exact tie, LSB odd -> rounds up to even
        run_op(7'h40, 7'h01, RN ? 7'h42 : 7'h41, 1'b0, 1'b0, 0, "tie");
        // P=0xFE01, guard 0 in both builds; held 5 cycles under backpressure
        run_op(7'h7F, 7'h7F, 7'h7E, 1'b1, 1'b0, 5, "max");
        // P=0x4101, guard 0
        run_op(7'h01, 7'h01, 7'h02, 1'b0, 1'b0, 0, "small");
        // P=0x7FF9: Zm=0x7F with guard+sticky, rounding wraps to a new leading bit
        run_op(7'h35, 7'h35, RN ? 7'h00 : 7'h7F, 1'b0, RN, 0, "rovf");

        // reset during the 4th MUL cycle discards the operation
        bus.Xm       = 7'h7F;
        bus.Ym       = 7'h7F;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst.rdy", 32'(bus.in_ready), 32'd1);
        chk("mrst.ov",  32'(bus.out_valid), 32'd0);
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid) saw++;
        end
        chk("mrst.noout", 32'(saw), 32'd0);
        run_op(7'h40, 7'h40, 7'h10, 1'b1, 1'b0, 0, "after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
